// File: rtl/seg7_multi_display.sv
// Multi-digit 7-segment display driver. It converts a binary value to decimal
// (double-dabble, one bit per cycle) or to hex, and can blank leading zeros
// and flash the display.
module seg7_multi_display #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       value,
  input  logic                    hex_mode,
  input  logic                    lz_blank,
  input  logic                    blink_en,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] leds
);

  // Decimal digits needed for 2^DATA_W-1 (floor(DATA_W*log10(2))+1).
  localparam int unsigned BcdRaw  = (DATA_W * 30103) / 100000 + 1;
  localparam int unsigned HexRaw  = (DATA_W + 3) / 4;
  localparam int unsigned DigTmp  = (BcdRaw > HexRaw) ? BcdRaw : HexRaw;
  // The digit register serves both modes and always covers every display digit.
  localparam int unsigned DigN    = (DigTmp > NUM_DIGITS) ? DigTmp : NUM_DIGITS;
  localparam int unsigned BcdW    = 4 * DigN;
  localparam int unsigned BitCntW = $clog2(DATA_W + 1);
  localparam int unsigned BlinkW  = $clog2(BLINK_DIV);

  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'b1111111;

  typedef enum logic [1:0] {StIdle, StConv, StUpdate} state_e;

  state_e                  state_q, state_d;
  logic                    pend_q, pend_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic                    hex_q, hex_d;
  logic                    lz_q, lz_d;
  logic [BcdW-1:0]         bcd_q, bcd_d;
  logic [BitCntW-1:0]      bitcnt_q, bitcnt_d;
  logic [7*NUM_DIGITS-1:0] leds_q, leds_d;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;
  logic [BlinkW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;

  logic [BcdW-1:0]         bcd_adj;
  logic                    ovf_calc;
  logic [7*NUM_DIGITS-1:0] disp;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Add-3 correction of every BCD digit that is 5 or more before the next shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(DigN); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Overflow detection, leading-zero blanking and segment decode of the digit register.
  always_comb begin
    logic zero_run;
    logic [3:0] d;
    ovf_calc = 1'b0;
    for (int k = int'(NUM_DIGITS); k < int'(DigN); k++) begin
      if (bcd_q[4*k +: 4] != 4'd0) begin
        ovf_calc = 1'b1;
      end
    end
    disp     = '1;
    zero_run = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      d        = bcd_q[4*k +: 4];
      zero_run = zero_run & (d == 4'd0);
      if (ovf_calc) begin
        disp[7*k +: 7] = SegDash;
      end else if (lz_q && zero_run && (k != 0)) begin
        disp[7*k +: 7] = SegBlank;
      end else begin
        disp[7*k +: 7] = seg_enc(d);
      end
    end
  end

  // Handshake FSM: capture on start, convert or pass through, then publish the result.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    shift_d  = shift_q;
    hex_d    = hex_q;
    lz_d     = lz_q;
    bcd_d    = bcd_q;
    bitcnt_d = bitcnt_q;
    leds_d   = leds_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A captured request is dispatched one edge later so busy rises after the accept.
        if (pend_q) begin
          pend_d = 1'b0;
          if (hex_q) begin
            bcd_d   = BcdW'(shift_q);
            state_d = StUpdate;
          end else begin
            bcd_d    = '0;
            bitcnt_d = '0;
            state_d  = StConv;
          end
        end else if (start) begin
          pend_d  = 1'b1;
          shift_d = value;
          hex_d   = hex_mode;
          lz_d    = lz_blank;
        end
      end
      StConv: begin
        bcd_d    = BcdW'({bcd_adj, shift_q[DATA_W-1]});
        shift_d  = shift_q << 1;
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == BitCntW'(DATA_W - 1)) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        leds_d  = disp;
        ovf_d   = ovf_calc;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Free-running blink divider, independent of the handshake.
  always_comb begin
    if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pend_q      <= 1'b0;
      shift_q     <= '0;
      hex_q       <= 1'b0;
      lz_q        <= 1'b0;
      bcd_q       <= '0;
      bitcnt_q    <= '0;
      leds_q      <= '1;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      shift_q     <= shift_d;
      hex_q       <= hex_d;
      lz_q        <= lz_d;
      bcd_q       <= bcd_d;
      bitcnt_q    <= bitcnt_d;
      leds_q      <= leds_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Outputs; blinking only masks the stored pattern.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = done_q;
    overflow = ovf_q;
    leds     = (blink_en && phase_q) ? '1 : leds_q;
  end

endmodule

// File: tb/tb_seg7_multi_display.sv
module tb_seg7_multi_display;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          hex_mode = 1'b0;
  logic          lz_blank = 1'b0;
  logic          blink_en = 1'b0;
  logic [DW-1:0] value = '0;
  logic          busy6, done6, ovf6, busy4, done4, ovf4;
  logic [41:0]   leds6;
  logic [27:0]   leds4;

  int n_checks = 0;
  int n_fail = 0;
  int ncyc = 0;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clk = ~clk;

  // Clock edges seen since reset release; the blink phase follows from it.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ncyc <= 0;
    else ncyc <= ncyc + 1;
  end

  seg7_multi_display #(.NUM_DIGITS(6), .DATA_W(DW), .BLINK_DIV(4)) u_dut6 (
    .clk(clk), .reset_n(reset_n), .start(start), .value(value), .hex_mode(hex_mode),
    .lz_blank(lz_blank), .blink_en(blink_en), .busy(busy6), .done(done6),
    .overflow(ovf6), .leds(leds6)
  );

  seg7_multi_display #(.NUM_DIGITS(4), .DATA_W(DW), .BLINK_DIV(6)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .value(value), .hex_mode(hex_mode),
    .lz_blank(lz_blank), .blink_en(blink_en), .busy(busy4), .done(done4),
    .overflow(ovf4), .leds(leds4)
  );

  // Reference display: digits by repeated division, leading zeros above the top nonzero digit.
  function automatic logic [55:0] model(input int ndig, input logic [DW-1:0] v, input bit hx,
                                        input bit lz, output bit ovf);
    logic [55:0] r;
    longint unsigned base, lim, rem;
    int d [8];
    int msd;
    r    = '1;
    base = hx ? 64'd16 : 64'd10;
    lim  = 1;
    for (int k = 0; k < ndig; k++) lim = lim * base;
    ovf = (longint'(v) >= lim);
    rem = longint'(v);
    msd = 0;
    for (int k = 0; k < 8; k++) begin
      d[k] = int'(rem % base);
      rem  = rem / base;
      if (d[k] != 0) msd = k;
    end
    for (int k = 0; k < ndig; k++) begin
      if (ovf) r[7*k +: 7] = 7'b0111111;
      else if (lz && k > msd) r[7*k +: 7] = 7'b1111111;
      else r[7*k +: 7] = seg_tab[d[k]];
    end
    return r;
  endfunction

  // Issues one request and follows it to done, noting handshake anomalies.
  task automatic convert(input logic [DW-1:0] v, input bit hx, input bit lz, input bit rel,
                         output int lat, output int hs_err, output bit got_done);
    @(negedge clk);
    if (rel) reset_n = 1'b1;
    start = 1'b1; value = v; hex_mode = hx; lz_blank = lz;
    @(posedge clk); #1;
    start = 1'b0; value = DW'($urandom); hex_mode = ~hx; lz_blank = ~lz;
    lat = 0; hs_err = 0; got_done = 1'b0;
    if (busy6 !== 1'b0 || done6 !== 1'b0) hs_err++;
    for (int i = 0; i < 100 && !got_done; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done6 === 1'b1) begin
        got_done = 1'b1;
        if (busy6 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b1) hs_err++;
      end else if (busy6 !== 1'b1 || busy4 !== 1'b1 || done4 !== 1'b0) begin
        hs_err++;
      end
    end
  endtask

  task automatic test_reset();
    #3 reset_n = 1'b0;
    start = 1'b1;
    #1;
    n_checks++;
    if ({busy6, done6, ovf6} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy6, done6, ovf6});
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (leds6 !== {42{1'b1}}) begin
      n_fail++; $display("FAIL reset_leds6: got %h expected %h", leds6, {42{1'b1}});
    end
    n_checks++;
    if ({busy4, done4, ovf4, leds4} !== {3'b000, {28{1'b1}}}) begin
      n_fail++; $display("FAIL reset_dut4: got %h expected %h", {busy4, done4, ovf4, leds4},
                         {3'b000, {28{1'b1}}});
    end
    start = 1'b0;
  endtask

  task automatic test_scenarios();
    int lat, hs; bit gd;
    // Decimal 1234 with leading-zero blanking (reset released together with start).
    convert(16'd1234, 1'b0, 1'b1, 1'b1, lat, hs, gd);
    n_checks++;
    if (!gd || lat != DW + 2) begin
      n_fail++; $display("FAIL s1_latency: got %0d (done=%0d) expected %0d", lat, gd, DW + 2);
    end
    n_checks++;
    if (hs != 0) begin n_fail++; $display("FAIL s1_handshake: got %0d errors expected 0", hs); end
    n_checks++;
    if (leds6 !== {7'h7f, 7'h7f, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}) begin
      n_fail++; $display("FAIL s1_leds: got %h expected %h", leds6,
                         {7'h7f, 7'h7f, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    end
    n_checks++;
    if (ovf6 !== 1'b0) begin n_fail++; $display("FAIL s1_ovf: got %b expected 0", ovf6); end
    @(posedge clk); #1;
    n_checks++;
    if (done6 !== 1'b0) begin n_fail++; $display("FAIL s1_done_width: got %b expected 0", done6); end
    // Zero shows a single 0.
    convert(16'd0, 1'b0, 1'b1, 1'b0, lat, hs, gd);
    n_checks++;
    if (leds6 !== {{5{7'h7f}}, 7'b1000000}) begin
      n_fail++; $display("FAIL s2_leds: got %h expected %h", leds6, {{5{7'h7f}}, 7'b1000000});
    end
    // Hex BEEF, no blanking.
    convert(16'hbeef, 1'b1, 1'b0, 1'b0, lat, hs, gd);
    n_checks++;
    if (!gd || lat != 2) begin
      n_fail++; $display("FAIL s3_latency: got %0d (done=%0d) expected 2", lat, gd);
    end
    n_checks++;
    if (leds6 !== {7'b1000000, 7'b1000000, 7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110}) begin
      n_fail++; $display("FAIL s3_leds: got %h expected %h", leds6,
                         {7'b1000000, 7'b1000000, 7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110});
    end
    n_checks++;
    if (hs != 0) begin n_fail++; $display("FAIL s3_handshake: got %0d errors expected 0", hs); end
    // 12345 overflows four digits but fits six.
    convert(16'd12345, 1'b0, 1'b0, 1'b0, lat, hs, gd);
    n_checks++;
    if (ovf4 !== 1'b1 || leds4 !== {4{7'b0111111}}) begin
      n_fail++; $display("FAIL s4_ovf4: got ovf=%b leds=%h expected ovf=1 leds=%h", ovf4, leds4,
                         {4{7'b0111111}});
    end
    n_checks++;
    if (ovf6 !== 1'b0 ||
        leds6 !== {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010}) begin
      n_fail++; $display("FAIL s4_leds6: got ovf=%b leds=%h expected ovf=0 leds=%h", ovf6, leds6,
                         {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010});
    end
  endtask

  task automatic test_start_while_busy();
    int dones; bit o; logic [55:0] e;
    @(negedge clk);
    start = 1'b1; value = 16'd500; hex_mode = 1'b0; lz_blank = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) begin
        start = 1'b1; value = 16'd999; hex_mode = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done6 === 1'b1) dones++;
    end
    start = 1'b0;
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL busy_ignore_dones: got %0d expected 1", dones); end
    e = model(6, 16'd500, 1'b0, 1'b1, o);
    n_checks++;
    if (leds6 !== e[41:0]) begin
      n_fail++; $display("FAIL busy_ignore_leds: got %h expected %h", leds6, e[41:0]);
    end
  endtask

  task automatic test_reset_abort();
    int lat, hs, dones; bit gd, o; logic [55:0] e;
    @(negedge clk);
    start = 1'b1; value = 16'd4321; hex_mode = 1'b0; lz_blank = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy6, done6, busy4, done4} !== 4'b0000 || leds6 !== {42{1'b1}}) begin
      n_fail++; $display("FAIL abort_state: got flags=%b leds=%h expected 0000 and %h",
                         {busy6, done6, busy4, done4}, leds6, {42{1'b1}});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done6 === 1'b1 || busy6 === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
    // First edge after release accepts start.
    #2 reset_n = 1'b0;
    convert(16'd77, 1'b0, 1'b1, 1'b1, lat, hs, gd);
    e = model(6, 16'd77, 1'b0, 1'b1, o);
    n_checks++;
    if (!gd || lat != DW + 2 || leds6 !== e[41:0]) begin
      n_fail++; $display("FAIL first_edge_accept: got lat=%0d leds=%h expected lat=%0d leds=%h",
                         lat, leds6, DW + 2, e[41:0]);
    end
  endtask

  task automatic test_random();
    int lat, hs; bit gd, eo6, eo4, hx, lz;
    logic [55:0] e6, e4;
    logic [31:0] msk;
    logic [DW-1:0] v;
    for (int it = 0; it < 24; it++) begin
      msk = (32'd1 << $urandom_range(1, DW)) - 32'd1;
      v   = DW'($urandom & msk);
      hx  = bit'($urandom_range(0, 1));
      lz  = bit'($urandom_range(0, 1));
      e6  = model(6, v, hx, lz, eo6);
      e4  = model(4, v, hx, lz, eo4);
      convert(v, hx, lz, 1'b0, lat, hs, gd);
      n_checks++;
      if (!gd || lat != (hx ? 2 : DW + 2) || hs != 0) begin
        n_fail++; $display("FAIL rnd_handshake v=%h hex=%0d: got lat=%0d errs=%0d expected lat=%0d",
                           v, hx, lat, hs, hx ? 2 : DW + 2);
      end
      n_checks++;
      if (leds6 !== e6[41:0] || ovf6 !== eo6) begin
        n_fail++; $display("FAIL rnd_dut6 v=%h hex=%0d lz=%0d: got %h/%b expected %h/%b",
                           v, hx, lz, leds6, ovf6, e6[41:0], eo6);
      end
      n_checks++;
      if (leds4 !== e4[27:0] || ovf4 !== eo4) begin
        n_fail++; $display("FAIL rnd_dut4 v=%h hex=%0d lz=%0d: got %h/%b expected %h/%b",
                           v, hx, lz, leds4, ovf4, e4[27:0], eo4);
      end
      if (it % 4 == 0) begin
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ovf4 !== eo4 || leds4 !== e4[27:0] || done4 !== 1'b0) begin
          n_fail++; $display("FAIL rnd_hold v=%h: got %b/%h expected %b/%h", v, ovf4, leds4,
                             eo4, e4[27:0]);
        end
      end
    end
  endtask

  task automatic test_blink();
    int lat, hs, bad6, bad4; bit gd;
    logic [41:0] s6;
    logic [27:0] s4;
    convert(16'd0, 1'b0, 1'b1, 1'b0, lat, hs, gd);
    s6 = {{5{7'h7f}}, 7'b1000000};
    s4 = {{3{7'h7f}}, 7'b1000000};
    @(negedge clk);
    blink_en = 1'b1;
    bad6 = 0; bad4 = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (leds6 !== (((ncyc / 4) % 2 == 1) ? {42{1'b1}} : s6)) bad6++;
      if (leds4 !== (((ncyc / 6) % 2 == 1) ? {28{1'b1}} : s4)) bad4++;
    end
    n_checks++;
    if (bad6 != 0) begin n_fail++; $display("FAIL blink_dut6: got %0d bad cycles expected 0", bad6); end
    n_checks++;
    if (bad4 != 0) begin n_fail++; $display("FAIL blink_dut4: got %0d bad cycles expected 0", bad4); end
    @(negedge clk);
    blink_en = 1'b0;
    bad6 = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (leds6 !== s6 || leds4 !== s4) bad6++;
    end
    n_checks++;
    if (bad6 != 0) begin n_fail++; $display("FAIL blink_off_steady: got %0d bad cycles expected 0", bad6); end
  endtask

  task automatic test_back_to_back();
    int lat, hs; bit gd, o; logic [55:0] e;
    logic [DW-1:0] vals [3] = '{16'd9876, 16'h0a5c, 16'd65535};
    bit hxs [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      convert(vals[i], hxs[i], 1'b0, 1'b0, lat, hs, gd);
      e = model(6, vals[i], hxs[i], 1'b0, o);
      n_checks++;
      if (!gd || lat != (hxs[i] ? 2 : DW + 2) || leds6 !== e[41:0] || ovf6 !== o) begin
        n_fail++; $display("FAIL b2b_%0d: got lat=%0d leds=%h ovf=%b expected lat=%0d leds=%h ovf=%b",
                           i, lat, leds6, ovf6, hxs[i] ? 2 : DW + 2, e[41:0], o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scenarios();
    test_start_while_busy();
    test_reset_abort();
    test_random();
    test_blink();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_multi_display.md
SEG7_MULTI_DISPLAY -- requirements
Module: seg7_multi_display

Interface
REQ-001 Parameter NUM_DIGITS, default 6, SHALL set the number of 7-segment digits driven (legal 1..8).
REQ-002 Parameter DATA_W, default 16, SHALL set the width of the binary input value (legal 1..32).
REQ-003 Parameter BLINK_DIV, default 25_000_000, SHALL set the clock cycles per blink half-period (legal >= 2).
REQ-004 The block SHALL use one clock and an asynchronous active-low reset, with these ports:
 - clk  in  1  system clock; all state changes on rising edge
 - reset_n  in  1  asynchronous, active-low reset
 - start  in  1  request to convert and display value
 - value  in  DATA_W  unsigned binary value to display
 - hex_mode  in  1  1 = hexadecimal digits; 0 = decimal digits
 - lz_blank  in  1  1 = blank leading zeros
 - blink_en  in  1  1 = flash the whole display
 - busy  out  1  conversion in progress
 - done  out  1  one-cycle pulse when new leds/overflow are valid
 - overflow  out  1  value does not fit in NUM_DIGITS
 - leds  out  7*NUM_DIGITS  active-low segments; digit k at [7k+6:7k], bit 6 = segment g, bit 0 = segment a

Function
REQ-005 States SHALL be IDLE, CONV and UPDATE.
REQ-006 In IDLE, start=1 SHALL be accepted on a rising edge (the accepting edge), capturing value, hex_mode and lz_blank.
REQ-007 start SHALL be ignored while busy=1 or in UPDATE; the in-flight conversion is unaffected.
REQ-008 Decimal mode: CONV SHALL perform shift-add-3 (double-dabble) binary-to-BCD conversion, one bit per cycle, for exactly DATA_W cycles, then enter UPDATE.
REQ-009 Hex mode: IDLE SHALL go directly to UPDATE; digit k equals nibble k of value, zero-extended to 4*NUM_DIGITS bits.
REQ-010 UPDATE SHALL last one cycle, then return to IDLE.
REQ-011 On the edge leaving UPDATE, leds and overflow SHALL be registered and done SHALL rise for exactly one cycle.
REQ-012 Latency from the accepting edge to done high SHALL be DATA_W+2 cycles (decimal) or 2 cycles (hex).
REQ-013 busy SHALL be high from the edge after the accepting edge until the edge on which done rises.
REQ-014 busy and done SHALL never be high in the same cycle.
REQ-015 The BCD register SHALL hold enough digits for 2^DATA_W-1; overflow=1 if any digit at index >= NUM_DIGITS is nonzero (decimal) or value >= 16^NUM_DIGITS (hex).
REQ-016 overflow SHALL hold its value until the next done.
REQ-017 On overflow, every digit SHALL show dash 7'b0111111, regardless of lz_blank.
REQ-018 Digit encodings SHALL be as follows (active-low, g..a):
 - 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000
 - A-F: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110
 - blank: 1111111
REQ-019 With lz_blank=1, all digits above the most-significant nonzero digit SHALL be blank.
REQ-020 Digit 0 SHALL never be blanked by lz_blank; value 0 shows "0".
REQ-021 Blink counter SHALL run freely 0..BLINK_DIV-1 and toggle a phase bit on wrap.
REQ-022 When blink_en=1 and phase=1, leds SHALL read all 1111111.
REQ-023 When blink_en=0 or phase=0, leds SHALL show the stored pattern; blinking SHALL NOT alter the stored pattern or the handshake.
REQ-024 The blink counter SHALL NOT depend on start, busy or done.

Reset
REQ-025 reset_n=0 SHALL asynchronously force the following: state IDLE, busy=0, done=0, overflow=0, all leds 1111111, blink counter 0, phase 0.
REQ-026 Reset asserted mid-CONV SHALL abort the conversion with no done pulse.
REQ-027 After reset_n deasserts, start SHALL be accepted on the first rising edge.

Verification
REQ-028 Scenario 1: defaults, value=1234, hex_mode=0, lz_blank=1 -> done 18 cycles after the accepting edge; digits 0..3 = 0011001, 0110000, 0100100, 1111001; digits 4-5 = 1111111; overflow=0.
REQ-029 Scenario 2: value=0, lz_blank=1, decimal -> digit 0 = 1000000; digits 1-5 blank.
REQ-030 Scenario 3: value=16'hBEEF, hex_mode=1, lz_blank=0 -> done 2 cycles after the accepting edge; digits 0..3 = 0001110, 0000110, 0000110, 0000011; digits 4-5 = 1000000.
REQ-031 Scenario 4: NUM_DIGITS=4, value=12345, decimal -> overflow=1; all four digits 0111111.
REQ-032 Scenario 5: start pulsed while busy -> ignored, and only one done follows. Then reset_n low mid-CONV -> busy 0, leds blank, no done.
REQ-033 Scenario 6: BLINK_DIV=4, blink_en=1 after showing "0" -> leds alternate between the stored pattern and all-blank every 4 cycles; blink_en=0 -> steady pattern.
